// File: rtl/halut_result_collector.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// halut_pkg
//   Shared HALUT configuration constants.
// ---------------------------------------------------------------------------
package halut_pkg;
    localparam int unsigned DecoderUnits = 4;
endpackage

// ---------------------------------------------------------------------------
// halut_result_collector
//   Captures the unthrottled result stream of the HALUT decoder array into a
//   small FIFO and re-emits it on a valid/ready interface. Each entry carries
//   the FP32 result, its decoder index and a row-end tag. The decoder-index
//   sequence of every burst is checked, and dropped inputs and ordering
//   faults are reported as sticky flags.
//
// Ports
//   clk_i        clock
//   rst_i        asynchronous reset, active-high
//   result_i     FP32 result from the decoder array
//   valid_i      result valid (no backpressure towards the decoders)
//   m_addr_i     decoder index of result_i
//   flush_i      synchronous flush of FIFO and order checker
//   clear_err_i  clears the sticky error flags
//   data_o       result at the FIFO head (0 when empty)
//   m_addr_o     decoder index at the FIFO head (0 when empty)
//   last_o       head entry is the last decoder index (0 when empty)
//   valid_o      FIFO not empty
//   ready_i      consumer accepts the head entry
//   fill_o       current FIFO occupancy
//   overflow_o   sticky: an input result was dropped
//   order_err_o  sticky: an out-of-sequence m_addr_i was received
// ---------------------------------------------------------------------------
module halut_result_collector #(
    parameter int unsigned DecoderUnits = halut_pkg::DecoderUnits,
    parameter int unsigned FifoDepth    = 4,
    parameter int unsigned DecAddrWidth = $clog2(DecoderUnits),
    parameter int unsigned FillWidth    = $clog2(FifoDepth + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [31:0]             result_i,
    input  logic                    valid_i,
    input  logic [DecAddrWidth-1:0] m_addr_i,
    input  logic                    flush_i,
    input  logic                    clear_err_i,
    output logic [31:0]             data_o,
    output logic [DecAddrWidth-1:0] m_addr_o,
    output logic                    last_o,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic [FillWidth-1:0]    fill_o,
    output logic                    overflow_o,
    output logic                    order_err_o
);

    localparam int unsigned PtrWidth = $clog2(FifoDepth);
    localparam logic [FillWidth-1:0]    FillMax = FillWidth'(FifoDepth);
    localparam logic [DecAddrWidth-1:0] LastIdx = DecAddrWidth'(DecoderUnits - 1);

    // Entry storage. Contents are don't-care after reset, so the arrays carry
    // no reset; emptiness is tracked solely by the fill counter.
    logic [31:0]             data_mem [FifoDepth];
    logic [DecAddrWidth-1:0] addr_mem [FifoDepth];
    logic                    last_mem [FifoDepth];

    logic [PtrWidth-1:0]     wr_ptr_q;
    logic [PtrWidth-1:0]     rd_ptr_q;
    logic [FillWidth-1:0]    fill_q;
    logic [DecAddrWidth-1:0] exp_q;
    logic                    overflow_q;
    logic                    order_err_q;

    logic full;
    logic empty;
    logic in_vld;
    logic pop;
    logic push;
    logic drop;
    logic order_bad;
    logic in_last;

    // ---- input qualification --------------------------------------------
    assign full    = (fill_q == FillMax);
    assign empty   = (fill_q == '0);
    assign in_vld  = valid_i && !flush_i;
    assign pop     = !empty && ready_i && !flush_i;
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign push    = in_vld && (!full || pop);
    assign drop    = in_vld && full && !pop;
    // Dropped inputs are still part of the burst, so they are checked too.
    assign order_bad = in_vld && (m_addr_i != exp_q);
    assign in_last   = (m_addr_i == LastIdx);

    // ---- storage write ---------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (push) begin
            data_mem[wr_ptr_q] <= result_i;
            addr_mem[wr_ptr_q] <= m_addr_i;
            last_mem[wr_ptr_q] <= in_last;
        end
    end

    // ---- pointers, fill and order tracking -------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
            exp_q    <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
            exp_q    <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrWidth'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrWidth'(1);
            end
            case ({push, pop})
                2'b10:   fill_q <= fill_q + FillWidth'(1);
                2'b01:   fill_q <= fill_q - FillWidth'(1);
                default: fill_q <= fill_q;
            endcase
            // Resynchronise on the received index; a gap restarts at 0
            // because the decoders begin every burst at index 0. The
            // increment wraps modulo DecoderUnits by width.
            if (valid_i) begin
                exp_q <= m_addr_i + DecAddrWidth'(1);
            end else begin
                exp_q <= '0;
            end
        end
    end

    // ---- sticky error flags (set has priority over clear) ----------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            overflow_q  <= 1'b0;
            order_err_q <= 1'b0;
        end else begin
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (clear_err_i) begin
                overflow_q <= 1'b0;
            end
            if (order_bad) begin
                order_err_q <= 1'b1;
            end else if (clear_err_i) begin
                order_err_q <= 1'b0;
            end
        end
    end

    // ---- head outputs ----------------------------------------------------
    // Driven from storage and the read pointer only; zero whenever empty,
    // which also covers the reset state.
    assign valid_o     = !empty;
    assign data_o      = empty ? 32'd0 : data_mem[rd_ptr_q];
    assign m_addr_o    = empty ? '0 : addr_mem[rd_ptr_q];
    assign last_o      = empty ? 1'b0 : last_mem[rd_ptr_q];
    assign fill_o      = fill_q;
    assign overflow_o  = overflow_q;
    assign order_err_o = order_err_q;

endmodule

// File: tb/tb_halut_result_collector.sv
`timescale 1ns/1ps
module tb_halut_result_collector;

    localparam int DU    = 4;
    localparam int DEPTH = 4;
    localparam int AW    = 2;
    localparam int FW    = 3;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [31:0]   result_i;
    logic          valid_i;
    logic [AW-1:0] m_addr_i;
    logic          flush_i;
    logic          clear_err_i;
    logic [31:0]   data_o;
    logic [AW-1:0] m_addr_o;
    logic          last_o;
    logic          valid_o;
    logic          ready_i;
    logic [FW-1:0] fill_o;
    logic          overflow_o;
    logic          order_err_o;

    halut_result_collector #(
        .DecoderUnits(DU),
        .FifoDepth   (DEPTH)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .result_i   (result_i),
        .valid_i    (valid_i),
        .m_addr_i   (m_addr_i),
        .flush_i    (flush_i),
        .clear_err_i(clear_err_i),
        .data_o     (data_o),
        .m_addr_o   (m_addr_o),
        .last_o     (last_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .fill_o     (fill_o),
        .overflow_o (overflow_o),
        .order_err_o(order_err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] d;
        int          a;
        bit          l;
    } ent_t;

    // Reference model state: the queue is the expected FIFO content.
    ent_t sb[$];
    bit   m_ovf;
    bit   m_ord;
    int   last_idx;   // index of previous valid input in this burst, -1 if none
    bit   pop_pend;   // consumer takes the head at the coming edge

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task model_reset();
        sb.delete();
        m_ovf    = 0;
        m_ord    = 0;
        last_idx = -1;
        pop_pend = 0;
    endtask

    always @(posedge rst_i) model_reset();

    // Reference model: updates at each clock edge from the applied inputs.
    always @(posedge clk_i) begin
        bit set_ovf, set_ord, was_pop, full;
        int e;
        set_ovf = 0;
        set_ord = 0;
        was_pop = pop_pend;
        pop_pend = 0;
        if (rst_i) begin
            model_reset();
        end else begin
            if (flush_i) begin
                sb.delete();
                last_idx = -1;
            end else if (valid_i) begin
                e = (last_idx < 0) ? 0 : (last_idx + 1) % DU;
                if (int'(m_addr_i) != e) set_ord = 1;
                last_idx = int'(m_addr_i);
                full = (sb.size() + (was_pop ? 1 : 0)) == DEPTH;
                if (!full || was_pop)
                    sb.push_back('{d: result_i, a: int'(m_addr_i), l: (int'(m_addr_i) == DU - 1)});
                else
                    set_ovf = 1;
            end else begin
                last_idx = -1;
            end
            if (set_ovf) m_ovf = 1; else if (clear_err_i) m_ovf = 0;
            if (set_ord) m_ord = 1; else if (clear_err_i) m_ord = 0;
        end
    end

    // Monitor: compares DUT outputs against the model between edges; the
    // consumer side pops the scoreboard when a transfer will happen.
    always @(negedge clk_i) begin
        chk("valid_o", valid_o, sb.size() != 0);
        chk("fill_o", fill_o, sb.size());
        chk("overflow_o", overflow_o, m_ovf);
        chk("order_err_o", order_err_o, m_ord);
        if (sb.size() != 0) begin
            chk("data_o", data_o, sb[0].d);
            chk("m_addr_o", m_addr_o, sb[0].a);
            chk("last_o", last_o, sb[0].l);
            if (ready_i && !flush_i && !rst_i) begin
                void'(sb.pop_front());
                pop_pend = 1;
            end
        end else begin
            chk("data_o_empty", data_o, 0);
            chk("m_addr_o_empty", m_addr_o, 0);
            chk("last_o_empty", last_o, 0);
        end
    end

    task automatic drive(input logic v, input int a, input logic [31:0] d,
                         input logic rdy, input logic fl, input logic clr);
        valid_i     = v;
        m_addr_i    = AW'(a);
        result_i    = d;
        ready_i     = rdy;
        flush_i     = fl;
        clear_err_i = clr;
        @(posedge clk_i);
        #2;
    endtask

    task automatic idle(input logic rdy, input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 32'h0, rdy, 0, 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_data"},  data_o, 0);
        chk({tag, "_addr"},  m_addr_o, 0);
        chk({tag, "_last"},  last_o, 0);
        chk({tag, "_valid"}, valid_o, 0);
        chk({tag, "_fill"},  fill_o, 0);
        chk({tag, "_ovf"},   overflow_o, 0);
        chk({tag, "_ord"},   order_err_o, 0);
    endtask

    logic [31:0] fp [4];
    int nxt;

    initial begin
        fp[0] = 32'h3F800000; fp[1] = 32'h40000000;
        fp[2] = 32'h40400000; fp[3] = 32'h40800000;
        rst_i = 1; valid_i = 0; m_addr_i = 0; result_i = 0;
        flush_i = 0; clear_err_i = 0; ready_i = 0;
        @(posedge clk_i); @(posedge clk_i); #2;
        chk_all_zero("reset");
        rst_i = 0;
        idle(1, 1);

        // Full-rate passthrough
        for (int i = 0; i < 4; i++) begin
            drive(1, i, fp[i], 1, 0, 0);
            chk("pass_fill_le1", fill_o <= 1, 1);
        end
        idle(1, 2);
        chk("pass_ovf", overflow_o, 0);
        chk("pass_ord", order_err_o, 0);

        // Backpressure and overflow
        for (int i = 0; i < 6; i++) drive(1, i % 4, 32'hA000_0000 + i, 0, 0, 0);
        chk("bp_fill", fill_o, 4);
        chk("bp_ovf", overflow_o, 1);
        chk("bp_head", data_o, 32'hA000_0000);
        idle(1, 4);
        chk("bp_drained", fill_o, 0);
        drive(0, 0, 0, 1, 0, 1);
        chk("bp_clear", overflow_o, 0);

        // Full with simultaneous push/pop
        for (int i = 0; i < 4; i++) drive(1, i, 32'hB000_0000 + i, 0, 0, 0);
        idle(0, 1);
        for (int i = 0; i < 3; i++) begin
            drive(1, i, 32'hC000_0000 + i, 1, 0, 0);
            chk("pp_fill", fill_o, 4);
        end
        chk("pp_ovf", overflow_o, 0);
        idle(1, 5);

        // Order error
        drive(1, 0, fp[0], 1, 0, 0);
        drive(1, 1, fp[1], 1, 0, 0);
        drive(1, 3, fp[3], 1, 0, 0);
        chk("ord_set", order_err_o, 1);
        drive(0, 0, 0, 1, 0, 1);
        chk("ord_clear", order_err_o, 0);
        drive(1, 0, fp[0], 1, 0, 0);
        drive(1, 1, fp[1], 1, 0, 0);
        chk("ord_resync", order_err_o, 0);
        drive(1, 3, fp[3], 1, 0, 1);
        chk("ord_set_wins", order_err_o, 1);
        drive(0, 0, 0, 1, 0, 1);
        idle(1, 2);

        // Flush
        for (int i = 0; i < 3; i++) drive(1, i, 32'hD000_0000 + i, 0, 0, 0);
        chk("fl_pre_fill", fill_o, 3);
        drive(1, 1, 32'hDEAD_BEEF, 0, 1, 0);
        chk("fl_valid", valid_o, 0);
        chk("fl_fill", fill_o, 0);
        chk("fl_ord", order_err_o, 0);
        chk("fl_ovf", overflow_o, 0);
        idle(1, 2);

        // Async reset mid-burst
        drive(1, 0, 32'hE000_0000, 0, 0, 0);
        drive(1, 1, 32'hE000_0001, 0, 0, 0);
        chk("rst_pre_fill", fill_o, 2);
        #1 rst_i = 1;
        #1 chk_all_zero("async_rst");
        @(posedge clk_i); #2;
        rst_i = 0;
        for (int i = 0; i < 4; i++) drive(1, i, fp[i], 1, 0, 0);
        idle(1, 2);
        chk("rst_after_ord", order_err_o, 0);

        // Randomised traffic
        nxt = 0;
        for (int c = 0; c < 600; c++) begin
            logic v, rdy, fl, clr;
            int a;
            v   = ($urandom_range(0, 9) < 7);
            rdy = ($urandom_range(0, 9) < 5);
            fl  = ($urandom_range(0, 59) == 0);
            clr = ($urandom_range(0, 19) == 0);
            a   = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, DU - 1)) : nxt;
            nxt = (v && !fl) ? (a + 1) % DU : 0;
            drive(v, a, $urandom, rdy, fl, clr);
        end
        idle(1, 6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
